// File: rtl/bus_port_pkg.sv
// Shared constants and helpers for the bus device port.
package bus_port_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  localparam int PKT_MAX_W = 64;

  // Destination ID is the top byte of the packet; msb is pckg_sz-1.
  function automatic logic [ID_W-1:0] get_dst(input logic [PKT_MAX_W-1:0] pkt,
                                               input int unsigned msb);
    logic [PKT_MAX_W-1:0] shifted;
    shifted = pkt >> (msb - (ID_W - 1));
    return shifted[ID_W-1:0];
  endfunction

endpackage

// File: rtl/bus_port_fifo.sv
// First-word fall-through synchronous FIFO with wrap-bit pointers.
// A write while full succeeds only when a read frees the slot on the same edge.
module bus_port_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd,
  output logic [width-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    count    = wr_ptr_q - rd_ptr_q;
    do_rd    = rd && !empty;
    do_wr    = wr && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: empty pointers mask stale contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/bus_dev_port.sv
// Device-side port for one driver slot: TX FIFO toward the bus, filtered RX FIFO from it.
// Define BUS_DEV_PORT_ADDR_FILTER_EN to accept only dev_id/broadcast; otherwise every push is taken.
module bus_dev_port
  import bus_port_pkg::*;
#(
  parameter int               pckg_sz   = 16,
  parameter int               depth     = 8,
  parameter logic [ID_W-1:0]  dev_id    = 8'd0,
  parameter logic [ID_W-1:0]  broadcast = BCAST_ID
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dev_tx_vld,
  output logic                     dev_tx_rdy,
  input  logic [pckg_sz-1:0]       dev_tx_data,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  output logic                     dev_rx_vld,
  output logic [pckg_sz-1:0]       dev_rx_data,
  input  logic                     dev_rx_rdy,
  output logic [$clog2(depth):0]   tx_count,
  output logic [7:0]               rx_drop_cnt,
  output logic                     pop_err
);

  logic [1:0]             rst_sync_q, rst_sync_d;
  logic                   rst_int;
  logic                   tx_full, tx_empty, tx_wr;
  logic                   rx_full, rx_empty, rx_wr, drop;
  logic                   match;
  logic [ID_W-1:0]        dst;
  logic [PKT_MAX_W-1:0]   push_ext;
  logic [$clog2(depth):0] rx_count_unused;
  logic [7:0]             drop_cnt_q, drop_cnt_d;
  logic                   pop_err_q, pop_err_d;

  // Reset asserts immediately and releases two clean edges later.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= rst_sync_d;
  end

  assign rst_int  = rst_sync_q[1];
  assign push_ext = {{(PKT_MAX_W-pckg_sz){1'b0}}, D_push};
  assign dst      = get_dst(push_ext, pckg_sz - 1);

`ifdef BUS_DEV_PORT_ADDR_FILTER_EN
  assign match = (dst == dev_id) || (dst == broadcast);
`else
  logic unused_filter;
  assign unused_filter = (dst == dev_id) || (dst == broadcast);
  assign match = 1'b1;
`endif

  always_comb begin
    dev_tx_rdy = !tx_full;
    pndng      = !tx_empty;
    dev_rx_vld = !rx_empty;
    tx_wr      = dev_tx_vld && dev_tx_rdy;
    rx_wr      = push && match;
    // A full RX FIFO still accepts if the device drains the head on this edge.
    drop       = push && match && rx_full && !dev_rx_rdy;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    pop_err_d  = pop_err_q || (pop && tx_empty);
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      drop_cnt_q <= '0;
      pop_err_q  <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      pop_err_q  <= pop_err_d;
    end
  end

  assign rx_drop_cnt = drop_cnt_q;
  assign pop_err     = pop_err_q;

  bus_port_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (rst_int),
    .wr      (tx_wr),
    .wr_data (dev_tx_data),
    .rd      (pop),
    .rd_data (D_pop),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  bus_port_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (rst_int),
    .wr      (rx_wr),
    .wr_data (D_push),
    .rd      (dev_rx_rdy),
    .rd_data (dev_rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count_unused)
  );

endmodule

// File: tb/tb_bus_dev_port.sv
// Directed self-checking bench for bus_dev_port (dev_id=2, depth=8, 16-bit packets).
module tb_bus_dev_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        dev_tx_vld;
  logic        dev_tx_rdy;
  logic [15:0] dev_tx_data;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        dev_rx_vld;
  logic [15:0] dev_rx_data;
  logic        dev_rx_rdy;
  logic [3:0]  tx_count;
  logic [7:0]  rx_drop_cnt;
  logic        pop_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_dev_port #(.pckg_sz(16), .depth(8), .dev_id(8'h02), .broadcast(8'hFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .dev_tx_vld  (dev_tx_vld),
    .dev_tx_rdy  (dev_tx_rdy),
    .dev_tx_data (dev_tx_data),
    .pndng       (pndng),
    .D_pop       (D_pop),
    .pop         (pop),
    .push        (push),
    .D_push      (D_push),
    .dev_rx_vld  (dev_rx_vld),
    .dev_rx_data (dev_rx_data),
    .dev_rx_rdy  (dev_rx_rdy),
    .tx_count    (tx_count),
    .rx_drop_cnt (rx_drop_cnt),
    .pop_err     (pop_err)
  );

  task automatic idle_inputs();
    dev_tx_vld  = 1'b0;
    dev_tx_data = '0;
    pop         = 1'b0;
    push        = 1'b0;
    D_push      = '0;
    dev_rx_rdy  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] seq [3];
    do_reset();
    checks++;
    if ({pndng, dev_rx_vld, D_pop, dev_rx_data, tx_count, rx_drop_cnt, pop_err, dev_tx_rdy}
        !== {1'b0, 1'b0, 16'h0, 16'h0, 4'd0, 8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: pndng=%b rx_vld=%b D_pop=%h rx_data=%h tx_count=%0d drop=%0d pop_err=%b rdy=%b",
               pndng, dev_rx_vld, D_pop, dev_rx_data, tx_count, rx_drop_cnt, pop_err, dev_tx_rdy);
    end
    seq = '{16'h0101, 16'h0102, 16'h0103};
    for (int i = 0; i < 3; i++) begin
      dev_tx_vld  = 1'b1;
      dev_tx_data = seq[i];
      @(negedge clk);
    end
    dev_tx_vld = 1'b0;
    checks++;
    if (tx_count !== 4'd3) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d want 3", tx_count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pndng, tx_count, D_pop} !== {1'b0, 4'd0, 16'h0}) begin
      errors++;
      $display("FAIL mid_reset: pndng=%b tx_count=%0d D_pop=%h want 0/0/0", pndng, tx_count, D_pop);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({pndng, tx_count} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL post_reset_empty: pndng=%b tx_count=%0d", pndng, tx_count);
    end
  endtask

  task automatic test_tx_order();
    logic [15:0] seq [3];
    seq = '{16'h0A01, 16'h0A02, 16'h0A03};
    for (int i = 0; i < 3; i++) begin
      dev_tx_vld  = 1'b1;
      dev_tx_data = seq[i];
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if ({pndng, D_pop} !== {1'b1, 16'h0A01}) begin
          errors++;
          $display("FAIL tx_latency: pndng=%b D_pop=%h want 1/0a01", pndng, D_pop);
        end
      end
    end
    dev_tx_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({pndng, D_pop} !== {1'b1, seq[i]}) begin
        errors++;
        $display("FAIL tx_order[%0d]: pndng=%b D_pop=%h want 1/%h", i, pndng, D_pop, seq[i]);
      end
      pop = 1'b1;
      @(negedge clk);
    end
    pop = 1'b0;
    checks++;
    if ({pndng, D_pop, tx_count} !== {1'b0, 16'h0, 4'd0}) begin
      errors++;
      $display("FAIL tx_drained: pndng=%b D_pop=%h count=%0d", pndng, D_pop, tx_count);
    end
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < 9; i++) begin
      dev_tx_vld  = 1'b1;
      dev_tx_data = 16'h1000 + 16'(i);
      @(negedge clk);
      if (i == 7) begin
        checks++;
        if ({dev_tx_rdy, tx_count} !== {1'b0, 4'd8}) begin
          errors++;
          $display("FAIL tx_full_8: rdy=%b count=%0d want 0/8", dev_tx_rdy, tx_count);
        end
      end
    end
    checks++;
    if ({tx_count, D_pop} !== {4'd8, 16'h1000}) begin
      errors++;
      $display("FAIL tx_ninth_blocked: count=%0d D_pop=%h want 8/1000", tx_count, D_pop);
    end
    dev_tx_data = 16'h1FFF;
    pop         = 1'b1;
    @(negedge clk);
    dev_tx_vld = 1'b0;
    pop        = 1'b0;
    checks++;
    if ({tx_count, D_pop, dev_tx_rdy} !== {4'd7, 16'h1001, 1'b1}) begin
      errors++;
      $display("FAIL tx_full_wr_pop: count=%0d D_pop=%h rdy=%b want 7/1001/1", tx_count, D_pop, dev_tx_rdy);
    end
    pop = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({tx_count, D_pop} !== {4'd1, 16'h1007}) begin
      errors++;
      $display("FAIL tx_full_tail: count=%0d D_pop=%h want 1/1007", tx_count, D_pop);
    end
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic test_rx_filter();
    logic [15:0] seq [3];
    seq = '{16'h02AA, 16'hFF55, 16'h0333};
    for (int i = 0; i < 3; i++) begin
      push   = 1'b1;
      D_push = seq[i];
      @(negedge clk);
    end
    push = 1'b0;
    dev_rx_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({dev_rx_vld, dev_rx_data} !== {1'b1, seq[i]}) begin
        errors++;
        $display("FAIL rx_filter[%0d]: vld=%b data=%h want 1/%h", i, dev_rx_vld, dev_rx_data, seq[i]);
      end
      dev_rx_rdy = 1'b1;
      @(negedge clk);
      dev_rx_rdy = 1'b0;
    end
`ifdef BUS_DEV_PORT_ADDR_FILTER_EN
    checks++;
    if ({dev_rx_vld, dev_rx_data} !== {1'b0, 16'h0}) begin
      errors++;
      $display("FAIL rx_filter_reject: vld=%b data=%h want 0/0000", dev_rx_vld, dev_rx_data);
    end
`else
    checks++;
    if ({dev_rx_vld, dev_rx_data} !== {1'b1, 16'h0333}) begin
      errors++;
      $display("FAIL rx_sniff_accept: vld=%b data=%h want 1/0333", dev_rx_vld, dev_rx_data);
    end
    dev_rx_rdy = 1'b1;
    @(negedge clk);
    dev_rx_rdy = 1'b0;
`endif
    checks++;
    if ({dev_rx_vld, rx_drop_cnt} !== {1'b0, 8'd0}) begin
      errors++;
      $display("FAIL rx_filter_end: vld=%b drop=%0d want 0/0", dev_rx_vld, rx_drop_cnt);
    end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] exp_drop;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push   = 1'b1;
      D_push = 16'h0200 + 16'(i);
      @(negedge clk);
    end
    push = 1'b0;
    checks++;
    if ({rx_drop_cnt, dev_rx_vld, dev_rx_data} !== {8'd2, 1'b1, 16'h0200}) begin
      errors++;
      $display("FAIL rx_overflow: drop=%0d vld=%b data=%h want 2/1/0200", rx_drop_cnt, dev_rx_vld, dev_rx_data);
    end
    push       = 1'b1;
    D_push     = 16'h02EE;
    dev_rx_rdy = 1'b1;
    @(negedge clk);
    dev_rx_rdy = 1'b0;
    checks++;
    if ({rx_drop_cnt, dev_rx_data} !== {8'd2, 16'h0201}) begin
      errors++;
      $display("FAIL rx_full_accept_read: drop=%0d data=%h want 2/0201", rx_drop_cnt, dev_rx_data);
    end
    D_push = 16'h0333;
    @(negedge clk);
`ifdef BUS_DEV_PORT_ADDR_FILTER_EN
    exp_drop = 8'd2;
`else
    exp_drop = 8'd3;
`endif
    checks++;
    if (rx_drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL rx_nomatch_full: drop=%0d want %0d", rx_drop_cnt, exp_drop);
    end
    D_push = 16'h02DD;
    repeat (300) @(negedge clk);
    push = 1'b0;
    checks++;
    if (rx_drop_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL rx_drop_sat: drop=%h want ff", rx_drop_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp;
      exp = (i < 7) ? 16'h0201 + 16'(i) : 16'h02EE;
      checks++;
      if ({dev_rx_vld, dev_rx_data} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL rx_drain[%0d]: vld=%b data=%h want 1/%h", i, dev_rx_vld, dev_rx_data, exp);
      end
      dev_rx_rdy = 1'b1;
      @(negedge clk);
    end
    dev_rx_rdy = 1'b0;
    checks++;
    if ({dev_rx_vld, dev_rx_data, rx_drop_cnt} !== {1'b0, 16'h0, 8'hFF}) begin
      errors++;
      $display("FAIL rx_drain_end: vld=%b data=%h drop=%h", dev_rx_vld, dev_rx_data, rx_drop_cnt);
    end
  endtask

  task automatic test_pop_err();
    do_reset();
    checks++;
    if (pop_err !== 1'b0) begin
      errors++;
      $display("FAIL pop_err_reset: got %b want 0", pop_err);
    end
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    checks++;
    if ({pop_err, pndng, tx_count} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL pop_err_set: pop_err=%b pndng=%b count=%0d want 1/0/0", pop_err, pndng, tx_count);
    end
    dev_tx_vld  = 1'b1;
    dev_tx_data = 16'h0B0B;
    pop         = 1'b1;
    @(negedge clk);
    dev_tx_vld = 1'b0;
    pop        = 1'b0;
    checks++;
    if ({tx_count, D_pop, pndng, pop_err} !== {4'd1, 16'h0B0B, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL empty_wr_pop: count=%0d D_pop=%h pndng=%b pop_err=%b want 1/0b0b/1/1",
               tx_count, D_pop, pndng, pop_err);
    end
  endtask

  task automatic test_back_to_back();
    dev_tx_vld  = 1'b1;
    dev_tx_data = 16'h0C0C;
    pop         = 1'b1;
    @(negedge clk);
    dev_tx_data = 16'h0D0D;
    @(negedge clk);
    dev_tx_vld = 1'b0;
    pop        = 1'b0;
    checks++;
    if ({tx_count, D_pop} !== {4'd1, 16'h0D0D}) begin
      errors++;
      $display("FAIL tx_wr_pop_b2b: count=%0d D_pop=%h want 1/0d0d", tx_count, D_pop);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_tx_order();
    test_tx_full();
    test_rx_filter();
    test_rx_overflow();
    test_pop_err();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
